// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: column-shift window, signed kernel, four-register
// pipeline (window, products, row sums, final sum) with valid/last tags.
module conv3x3_engine #(
   parameter int W    = 5,
   parameter int H    = 5,
   parameter int RELU = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  row0,
   input  logic [7:0]  row1,
   input  logic [7:0]  row2,
   input  logic        in_valid,
   input  logic        w_we,
   input  logic [3:0]  w_addr,
   input  logic [7:0]  w_data,
   output logic [19:0] out_data,
   output logic        out_valid,
   output logic        out_last
);

   localparam int CW = (W > 2) ? $clog2(W) : 2;
   localparam int RW = (H > 2) ? $clog2(H) : 2;

   logic [7:0]         win_q [3][3];
   logic [7:0]         win_d [3][3];
   logic [7:0]         tap [3];
   logic signed [7:0]  w_q [9];
   logic signed [7:0]  w_d [9];
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic               v1_q, v1_d, l1_q, l1_d;
   logic signed [16:0] prod_q [9];
   logic signed [16:0] prod_d [9];
   logic               v2_q, v2_d, l2_q, l2_d;
   logic signed [19:0] rsum_q [3];
   logic signed [19:0] rsum_d [3];
   logic               v3_q, v3_d, l3_q, l3_d;
   logic signed [19:0] total;
   logic [19:0]        out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d, out_last_q, out_last_d;

   always_comb begin
      tap[0] = row2;
      tap[1] = row1;
      tap[2] = row0;
      win_d  = win_q;
      col_d  = col_q;
      row_d  = row_q;
      v1_d   = 1'b0;
      l1_d   = 1'b0;
      w_d    = w_q;
      for (int k = 0; k < 9; k++) begin
         if (w_we && w_addr == 4'(k)) w_d[k] = w_data;
      end
      if (in_valid) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
            win_d[i][2] = tap[i];
         end
         // Tags use the position of the sample being accepted, before the counters advance.
         v1_d = (col_q >= CW'(2)) && (row_q >= RW'(2));
         l1_d = (col_q == CW'(W-1)) && (row_q == RW'(H-1));
         if (col_q == CW'(W-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(H-1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            prod_d[3*i+j] = 17'($signed({1'b0, win_q[i][j]})) * 17'(w_q[3*i+j]);
         end
      end
      v2_d = v1_q;
      l2_d = l1_q;
      for (int i = 0; i < 3; i++) begin
         rsum_d[i] = 20'(prod_q[3*i]) + 20'(prod_q[3*i+1]) + 20'(prod_q[3*i+2]);
      end
      v3_d        = v2_q;
      l3_d        = l2_q;
      total       = rsum_q[0] + rsum_q[1] + rsum_q[2];
      out_data_d  = (RELU != 0 && total[19]) ? 20'd0 : total;
      out_valid_d = v3_q;
      out_last_d  = l3_q & v3_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
            rsum_q[i] <= '0;
         end
         for (int k = 0; k < 9; k++) begin
            w_q[k]    <= '0;
            prod_q[k] <= '0;
         end
         col_q       <= '0;
         row_q       <= '0;
         v1_q        <= 1'b0;
         l1_q        <= 1'b0;
         v2_q        <= 1'b0;
         l2_q        <= 1'b0;
         v3_q        <= 1'b0;
         l3_q        <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         win_q       <= win_d;
         w_q         <= w_d;
         col_q       <= col_d;
         row_q       <= row_d;
         v1_q        <= v1_d;
         l1_q        <= l1_d;
         prod_q      <= prod_d;
         v2_q        <= v2_d;
         l2_q        <= l2_d;
         rsum_q      <= rsum_d;
         v3_q        <= v3_d;
         l3_q        <= l3_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Consumes the three vertically aligned row taps from the line-buffer stage, one column per accepted sample.
- Builds a 3x3 pixel window in column shift registers and convolves it with a loadable signed 3x3 kernel.
- The multiply/adder pipeline emits one result per interior window position, with valid and end-of-frame flags, to the activation/pooling stage downstream.

Parameters:
- W, 5, image width in pixels; must match the line-buffer W.
- H, 5, image height in lines.
- RELU, 0, when 1, negative results are clamped to 0 before output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row0  input  8  unsigned pixel, current (newest) line.
- row1  input  8  unsigned pixel, one line above.
- row2  input  8  unsigned pixel, two lines above (oldest).
- in_valid  input  1  row0..row2 carry a new column this cycle; integrator delays upstream pixel_valid by one cycle to align with the registered taps.
- w_we  input  1  kernel weight write strobe.
- w_addr  input  4  weight index k = 3*i + j; i = 0 top (row2) .. 2 bottom (row0); j = 0 left (oldest column) .. 2 right (newest).
- w_data  input  8  signed two's-complement weight.
- out_data  output  20  signed convolution result.
- out_valid  output  1  out_data valid this cycle.
- out_last  output  1  with out_valid, marks last window of the frame.

Behaviour:
- Reset (asynchronous, active-high): window registers, weights, col/row counters, pipeline registers and outputs all 0. out_valid=0, out_last=0, out_data=0. Reset mid-frame discards in-flight results; no output after release until a fresh frame.
- Window stage: on in_valid, each tap row shifts.
  - win[i][0] <= win[i][1]
  - win[i][1] <= win[i][2]
  - win[i][2] <= new tap (row2 for i=0, row1 for i=1, row0 for i=2)
  - Without in_valid, window and counters hold.
- Counters: col 0..W-1, row 0..H-1, advanced per accepted sample.
  - col wraps to 0 and row increments at W-1.
  - At (H-1, W-1), both wrap to 0 for the next frame.
- Window valid tag: set for the sample accepted with col>=2 and row>=2. Gives (W-2)*(H-2) results per frame; wrap-around windows at line starts are masked.
- Last tag: set when the accepted sample is (row H-1, col W-1).
- Stage 2 (products): nine registered products, pixel zero-extended to 9 bits times signed weight, 17-bit signed each. Valid/last tags advance with the data.
- Stage 3 (sum): signed sum of nine products, registered into out_data.
  - Range is ±293760, so 20 bits never overflow.
  - RELU=1: result <0 outputs 0.
  - out_valid = stage tag; out_last = last tag AND valid.
- Latency: sample accepted at edge N produces out_valid high after edge N+3 (3 clocks). Pipeline stages 2 and 3 advance every cycle regardless of in_valid, so the output is a single-cycle pulse per window. Gaps in in_valid only delay results.
- No backpressure: downstream must accept every out_valid cycle.
- Weights:
  - w_we writes w[w_addr] <= w_data at the edge.
  - w_addr 9..15 is ignored.
  - A weight written at edge N is used by the product stage from edge N+1. A simultaneous window-stage update uses the new weight only for samples reaching stage 2 after the write.
  - Reset clears all weights to 0, so output is 0 until loaded.

Test Plan:
- Identity kernel, ramp frame: load w[4]=1, others 0, RELU=0. Stream 5x5 frame, pixel = 10*r+c, in_valid continuous. Expect exactly 9 outputs with values 11,12,13,21,22,23,31,32,33. out_last on the 9th only. First out_valid 3 clocks after the sample at (2,2).
- Max positive: all weights 1, all pixels 255 -> every output 2295.
- Max negative, both RELU settings: all weights -128, all pixels 255.
  - RELU=0: every output -293760 (20'h B8480).
  - RELU=1: every output 0.
- Bubbles: same ramp/identity as the first scenario, with in_valid low for 2 cycles after every accepted sample. Expect the same 9 values in order, each out_valid a single-cycle pulse.
- Reset mid-frame: assert rst asynchronously (between edges) after 14 samples. Outputs go 0 immediately. Then reload w[4]=1 and stream a full frame; expect exactly 9 correct outputs, no stale results.
- Weight load/invalid address: write w_addr=9 with data 1 -> no effect, all outputs 0. Back-to-back frames with continuous in_valid -> 18 outputs, out_last on 9th and 18th.
